cfg_mgmt_axis_bridge: RTL and testbench

Bridges the SoC configuration-space DMA stream pair to the PCIe endpoint `cfg_mgmt_*` port. It sits between the DMA channel-1 MM2S/S2MM streams and the 7-series PCIe core in the `user_clk` domain. Each request stream packet is decoded into exactly one config read or write. The block holds the strobe until the core reports done, then returns exactly one response beat with data and status, using a bounded timeout so a missing done cannot hang the DMA.

---
 rtl/cfg_bridge_pkg.sv | 21 ++
 rtl/cfg_mgmt_axis_bridge_if.sv | 43 ++++
 rtl/cfg_mgmt_axis_bridge.sv | 121 ++++++++++++
 tb/tb_cfg_mgmt_axis_bridge.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cfg_bridge_pkg.sv
// cfg_bridge_pkg: header field positions, FSM state codes and response status codes
// for the config-management stream bridge.
package cfg_bridge_pkg;
   localparam int ADDR_LSB = 0;
   localparam int ADDR_MSB = 9;
   localparam int BE_LSB   = 10;
   localparam int WR_BIT   = 16;
   localparam int RO_BIT   = 17;
   localparam int RW1C_BIT = 18;

   typedef logic [2:0] state_t;
   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_DATA  = 3'd1;
   localparam state_t S_DRAIN = 3'd2;
   localparam state_t S_ISSUE = 3'd3;
   localparam state_t S_RESP  = 3'd4;

   localparam logic [1:0] ST_OK        = 2'd0;
   localparam logic [1:0] ST_TIMEOUT   = 2'd1;
   localparam logic [1:0] ST_MALFORMED = 2'd2;
endpackage

// File: rtl/cfg_mgmt_axis_bridge_if.sv
// cfg_mgmt_axis_bridge_if: request/response streams plus the PCIe cfg_mgmt port;
// master is the bridge side, slave is the DMA/core environment side.
interface cfg_mgmt_axis_bridge_if;
   logic [31:0] s_axis_req_tdata;
   logic        s_axis_req_tvalid;
   logic        s_axis_req_tready;
   logic        s_axis_req_tlast;
   logic [31:0] m_axis_rsp_tdata;
   logic        m_axis_rsp_tvalid;
   logic        m_axis_rsp_tready;
   logic        m_axis_rsp_tlast;
   logic [3:0]  m_axis_rsp_tkeep;
   logic [1:0]  m_axis_rsp_tuser;
   logic [9:0]  cfg_mgmt_dwaddr;
   logic [3:0]  cfg_mgmt_byte_en;
   logic [31:0] cfg_mgmt_di;
   logic        cfg_mgmt_rd_en;
   logic        cfg_mgmt_wr_en;
   logic        cfg_mgmt_wr_readonly;
   logic        cfg_mgmt_wr_rw1c_as_rw;
   logic [31:0] cfg_mgmt_do;
   logic        cfg_mgmt_rd_wr_done;

   modport master (
      input  s_axis_req_tdata, s_axis_req_tvalid, s_axis_req_tlast,
      output s_axis_req_tready,
      output m_axis_rsp_tdata, m_axis_rsp_tvalid, m_axis_rsp_tlast, m_axis_rsp_tkeep, m_axis_rsp_tuser,
      input  m_axis_rsp_tready,
      output cfg_mgmt_dwaddr, cfg_mgmt_byte_en, cfg_mgmt_di, cfg_mgmt_rd_en, cfg_mgmt_wr_en,
      output cfg_mgmt_wr_readonly, cfg_mgmt_wr_rw1c_as_rw,
      input  cfg_mgmt_do, cfg_mgmt_rd_wr_done
   );

   modport slave (
      output s_axis_req_tdata, s_axis_req_tvalid, s_axis_req_tlast,
      input  s_axis_req_tready,
      input  m_axis_rsp_tdata, m_axis_rsp_tvalid, m_axis_rsp_tlast, m_axis_rsp_tkeep, m_axis_rsp_tuser,
      output m_axis_rsp_tready,
      input  cfg_mgmt_dwaddr, cfg_mgmt_byte_en, cfg_mgmt_di, cfg_mgmt_rd_en, cfg_mgmt_wr_en,
      input  cfg_mgmt_wr_readonly, cfg_mgmt_wr_rw1c_as_rw,
      output cfg_mgmt_do, cfg_mgmt_rd_wr_done
   );
endinterface

// File: rtl/cfg_mgmt_axis_bridge.sv
// cfg_mgmt_axis_bridge: decodes one request packet into one cfg_mgmt read/write,
// waits for done (bounded by TIMEOUT_CYCLES) and returns one status/data beat.
module cfg_mgmt_axis_bridge
   import cfg_bridge_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                   user_clk,
   input  logic                   user_rst_n,
   cfg_mgmt_axis_bridge_if.master bus
);
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rdy_q;
   logic [9:0]    addr_q, addr_d;
   logic [3:0]    be_q, be_d;
   logic [31:0]   di_q, di_d;
   logic          wr_q, wr_d, ro_q, ro_d, rw1c_q, rw1c_d;
   logic [31:0]   data_q, data_d;
   logic [1:0]    user_q, user_d;
   logic          req_fire;
   logic [31:0]   hdr;

   assign hdr      = bus.s_axis_req_tdata;
   assign req_fire = bus.s_axis_req_tvalid && bus.s_axis_req_tready;

   always_comb begin
      state_d = state_q;
      cnt_d   = (state_q == S_ISSUE) ? cnt_q + 1'b1 : '0;
      addr_d  = addr_q;
      be_d    = be_q;
      di_d    = di_q;
      wr_d    = wr_q;
      ro_d    = ro_q;
      rw1c_d  = rw1c_q;
      data_d  = data_q;
      user_d  = user_q;
      case (state_q)
         S_IDLE: if (req_fire) begin
            addr_d  = hdr[ADDR_MSB:ADDR_LSB];
            wr_d    = hdr[WR_BIT];
            be_d    = hdr[WR_BIT] ? hdr[BE_LSB +: 4] : 4'h0;
            ro_d    = hdr[RO_BIT];
            rw1c_d  = hdr[RW1C_BIT];
            state_d = hdr[WR_BIT] ? (bus.s_axis_req_tlast ? S_RESP : S_DATA)
                                  : (bus.s_axis_req_tlast ? S_ISSUE : S_DRAIN);
            if (hdr[WR_BIT] && bus.s_axis_req_tlast) begin
               data_d = '0;
               user_d = ST_MALFORMED;
            end
         end
         S_DATA: if (req_fire) begin
            di_d    = hdr;
            state_d = bus.s_axis_req_tlast ? S_ISSUE : S_DRAIN;
         end
         S_DRAIN: if (req_fire && bus.s_axis_req_tlast) begin
            state_d = S_RESP;
            data_d  = '0;
            user_d  = ST_MALFORMED;
         end
         // done takes priority over an expiry in the same cycle
         S_ISSUE: if (bus.cfg_mgmt_rd_wr_done) begin
            state_d = S_RESP;
            data_d  = wr_q ? '0 : bus.cfg_mgmt_do;
            user_d  = ST_OK;
         end else if (cnt_q == CNT_LAST) begin
            state_d = S_RESP;
            data_d  = '0;
            user_d  = ST_TIMEOUT;
         end
         S_RESP: if (bus.m_axis_rsp_tready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rdy_q   <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         di_q    <= '0;
         wr_q    <= 1'b0;
         ro_q    <= 1'b0;
         rw1c_q  <= 1'b0;
         data_q  <= '0;
         user_q  <= ST_OK;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdy_q   <= 1'b1;
         addr_q  <= addr_d;
         be_q    <= be_d;
         di_q    <= di_d;
         wr_q    <= wr_d;
         ro_q    <= ro_d;
         rw1c_q  <= rw1c_d;
         data_q  <= data_d;
         user_q  <= user_d;
      end
   end

   // rdy_q keeps tready low while reset is held even though the state is IDLE
   assign bus.s_axis_req_tready = rdy_q && (state_q == S_IDLE || state_q == S_DATA || state_q == S_DRAIN);
   assign bus.m_axis_rsp_tvalid = state_q == S_RESP;
   assign bus.m_axis_rsp_tdata  = data_q;
   assign bus.m_axis_rsp_tuser  = user_q;
   assign bus.m_axis_rsp_tlast  = 1'b1;
   assign bus.m_axis_rsp_tkeep  = 4'hF;
   assign bus.cfg_mgmt_dwaddr   = addr_q;
   assign bus.cfg_mgmt_byte_en  = be_q;
   assign bus.cfg_mgmt_di       = di_q;
   assign bus.cfg_mgmt_rd_en    = state_q == S_ISSUE && !wr_q;
   assign bus.cfg_mgmt_wr_en    = state_q == S_ISSUE && wr_q;
   assign bus.cfg_mgmt_wr_readonly   = ro_q;
   assign bus.cfg_mgmt_wr_rw1c_as_rw = rw1c_q;
endmodule

// File: tb/tb_cfg_mgmt_axis_bridge.sv
// tb_cfg_mgmt_axis_bridge: directed and random request packets against a packet-level
// model of the bridge (status, data, strobe length, latency) with a scripted PCIe core.
module tb_cfg_mgmt_axis_bridge;
   localparam int TO = 16;

   logic user_clk   = 1'b0;
   logic user_rst_n = 1'b0;
   int   compared   = 0;
   int   mismatched = 0;

   cfg_mgmt_axis_bridge_if bus();

   cfg_mgmt_axis_bridge #(.TIMEOUT_CYCLES(TO)) dut (
      .user_clk   (user_clk),
      .user_rst_n (user_rst_n),
      .bus        (bus)
   );

   always #5 user_clk = ~user_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge user_clk);
      #1;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic last, output bit ok);
      bus.s_axis_req_tdata  = d;
      bus.s_axis_req_tlast  = last;
      bus.s_axis_req_tvalid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         ok = bus.s_axis_req_tready;
         tick();
      end
      bus.s_axis_req_tvalid = 1'b0;
      bus.s_axis_req_tlast  = 1'b0;
   endtask

   // dly: strobe cycle on which the core pulses done (0 = never); bp: cycles of
   // response backpressure; late: backpressure cycle on which a stray done is pulsed
   task automatic txn(input string tag, input logic [31:0] hdr, input logic [31:0] wdata,
                      input int nbeats, input int dly, input logic [31:0] do_val,
                      input int bp, input int late);
      bit          wr       = hdr[16];
      bit          mal      = wr ? (nbeats != 2) : (nbeats != 1);
      bit          done_ok  = !mal && dly >= 1 && dly <= TO;
      int          exp_strb = mal ? 0 : (done_ok ? dly : TO);
      logic [1:0]  exp_st   = mal ? 2'd2 : (done_ok ? 2'd0 : 2'd1);
      logic [31:0] exp_data = (done_ok && !wr) ? do_val : 32'h0;
      int          acc = 0, strb = 0, lat;
      bit          ok, unstable = 0, busy_rdy = 0;
      logic [9:0]  a0 = '0;
      logic [3:0]  b0 = '0, f0 = '0;
      logic [31:0] d0 = '0, rsp_d;
      logic [1:0]  rsp_u;
      for (int b = 0; b < nbeats; b++) begin
         send_beat(b == 0 ? hdr : (b == 1 ? wdata : $urandom()), b == nbeats - 1, ok);
         acc += int'(ok);
      end
      check({tag, "/accepted"}, acc, nbeats);
      for (lat = 0; lat < 200 && !bus.m_axis_rsp_tvalid; lat++) begin
         if (bus.cfg_mgmt_rd_en || bus.cfg_mgmt_wr_en) begin
            strb++;
            if (bus.s_axis_req_tready) busy_rdy = 1'b1;
            if (strb == 1) begin
               a0 = bus.cfg_mgmt_dwaddr;
               b0 = bus.cfg_mgmt_byte_en;
               d0 = bus.cfg_mgmt_di;
               f0 = {bus.cfg_mgmt_rd_en, bus.cfg_mgmt_wr_en, bus.cfg_mgmt_wr_readonly, bus.cfg_mgmt_wr_rw1c_as_rw};
            end else if (a0 !== bus.cfg_mgmt_dwaddr || b0 !== bus.cfg_mgmt_byte_en || d0 !== bus.cfg_mgmt_di ||
                         f0 !== {bus.cfg_mgmt_rd_en, bus.cfg_mgmt_wr_en, bus.cfg_mgmt_wr_readonly, bus.cfg_mgmt_wr_rw1c_as_rw})
               unstable = 1'b1;
         end
         bus.cfg_mgmt_rd_wr_done = (bus.cfg_mgmt_rd_en || bus.cfg_mgmt_wr_en) && strb == dly;
         bus.cfg_mgmt_do = bus.cfg_mgmt_rd_wr_done ? do_val : $urandom();
         tick();
      end
      bus.cfg_mgmt_rd_wr_done = 1'b0;
      check({tag, "/rsp_valid"}, bus.m_axis_rsp_tvalid, 1);
      check({tag, "/latency"}, lat, exp_strb);
      check({tag, "/strobe_cycles"}, strb, exp_strb);
      check({tag, "/rsp_data"}, bus.m_axis_rsp_tdata, exp_data);
      check({tag, "/rsp_status"}, bus.m_axis_rsp_tuser, exp_st);
      check({tag, "/rsp_last_keep"}, {bus.m_axis_rsp_tlast, bus.m_axis_rsp_tkeep}, 5'h1F);
      check({tag, "/req_busy"}, {busy_rdy, bus.s_axis_req_tready}, 0);
      if (exp_strb > 0) begin
         check({tag, "/kind"}, f0[3:2], {!wr, wr});
         check({tag, "/addr"}, a0, hdr[9:0]);
         check({tag, "/byte_en"}, b0, wr ? hdr[13:10] : 4'h0);
         check({tag, "/stable"}, unstable, 0);
         if (wr) begin
            check({tag, "/di"}, d0, wdata);
            check({tag, "/flags"}, f0[1:0], {hdr[17], hdr[18]});
         end
      end
      rsp_d = bus.m_axis_rsp_tdata;
      rsp_u = bus.m_axis_rsp_tuser;
      for (int i = 0; i < bp; i++) begin
         bus.cfg_mgmt_rd_wr_done = (i == late);
         bus.cfg_mgmt_do = 32'hDEAD_BEEF;
         tick();
         bus.cfg_mgmt_rd_wr_done = 1'b0;
         check({tag, "/bp_hold"}, {bus.m_axis_rsp_tvalid, bus.s_axis_req_tready, bus.m_axis_rsp_tuser, bus.m_axis_rsp_tdata[27:0]},
               {1'b1, 1'b0, rsp_u, rsp_d[27:0]});
         check({tag, "/bp_data"}, bus.m_axis_rsp_tdata, exp_data);
      end
      bus.m_axis_rsp_tready = 1'b1;
      tick();
      bus.m_axis_rsp_tready = 1'b0;
      check({tag, "/after_hs"}, {bus.m_axis_rsp_tvalid, bus.s_axis_req_tready, bus.cfg_mgmt_rd_en, bus.cfg_mgmt_wr_en}, 4'b0100);
   endtask

   initial begin
      bit ok;
      int seen;
      bus.s_axis_req_tdata    = '0;
      bus.s_axis_req_tvalid   = 1'b0;
      bus.s_axis_req_tlast    = 1'b0;
      bus.m_axis_rsp_tready   = 1'b0;
      bus.cfg_mgmt_do         = '0;
      bus.cfg_mgmt_rd_wr_done = 1'b0;
      repeat (3) tick();
      check("rst/req_tready", bus.s_axis_req_tready, 0);
      check("rst/rsp", {bus.m_axis_rsp_tvalid, bus.m_axis_rsp_tuser, bus.m_axis_rsp_tdata}, 35'h0);
      check("rst/cfg_ctl", {bus.cfg_mgmt_rd_en, bus.cfg_mgmt_wr_en, bus.cfg_mgmt_wr_readonly,
                            bus.cfg_mgmt_wr_rw1c_as_rw, bus.cfg_mgmt_byte_en, bus.cfg_mgmt_dwaddr}, 0);
      check("rst/cfg_di", bus.cfg_mgmt_di, 0);
      user_rst_n = 1'b1;
      tick();
      check("rst/req_tready_after", bus.s_axis_req_tready, 1);

      txn("read",      32'h0000_0000, 32'h0,         1, 4,      32'h7024_10EE, 0,  -1);
      txn("write",     32'h0001_3C04, 32'hFFFF_FFFF, 2, 3,      32'h1234_5678, 0,  -1);
      txn("min_read",  32'h0000_0123, 32'h0,         1, 1,      32'h89AB_CDEF, 0,  -1);
      txn("timeout",   32'h0000_0010, 32'h0,         1, 0,      32'h0,         8,  4);
      txn("after_to",  32'h0000_0011, 32'h0,         1, 2,      32'hCAFE_F00D, 0,  -1);
      txn("done_wins", 32'h0000_03FF, 32'h0,         1, TO,     32'h5555_AAAA, 0,  -1);
      txn("to_edge",   32'h0007_0200, 32'h0BAD_F00D, 2, TO + 1, 32'h0,         0,  -1);
      txn("wr_flags",  32'h0006_2401, 32'h0000_00FF, 2, 2,      32'h0,         0,  -1);
      txn("mal_wr1",   32'h0001_0005, 32'h0,         1, 2,      32'h1111_1111, 0,  -1);
      txn("mal_rd3",   32'h0000_0007, 32'hA5A5_A5A5, 3, 2,      32'h2222_2222, 0,  -1);
      txn("mal_wr3",   32'h0001_0008, 32'h5A5A_5A5A, 3, 2,      32'h3333_3333, 0,  -1);
      txn("bp",        32'h0000_0042, 32'h0,         1, 2,      32'h0F0F_0F0F, 10, -1);

      send_beat(32'h0000_0055, 1'b1, ok);
      check("rst_mid/accepted", ok, 1);
      tick();
      tick();
      check("rst_mid/strobe", bus.cfg_mgmt_rd_en, 1);
      #3 user_rst_n = 1'b0;
      #1 check("rst_mid/async_drop", {bus.cfg_mgmt_rd_en, bus.cfg_mgmt_wr_en, bus.s_axis_req_tready, bus.m_axis_rsp_tvalid}, 0);
      tick();
      user_rst_n = 1'b1;
      seen = 0;
      bus.m_axis_rsp_tready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.cfg_mgmt_rd_wr_done = (i == 1);
         tick();
         seen += int'(bus.m_axis_rsp_tvalid || bus.cfg_mgmt_rd_en);
      end
      bus.cfg_mgmt_rd_wr_done = 1'b0;
      bus.m_axis_rsp_tready = 1'b0;
      check("rst_mid/no_replay", seen, 0);
      check("rst_mid/ready", bus.s_axis_req_tready, 1);
      txn("rst_mid/next", 32'h0000_0055, 32'h0, 1, 3, 32'h600D_600D, 0, -1);

      for (int n = 0; n < 24; n++) begin
         logic [31:0] h = $urandom();
         int          k = $urandom_range(0, 9);
         h[16] = k[0];
         txn($sformatf("rand%0d", n), h, $urandom(),
             (k >= 8) ? $urandom_range(1, 3) : (k[0] ? 2 : 1),
             $urandom_range(0, TO + 4), $urandom(), $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
